// File: rtl/tri_512x16_ary_ctl.sv
// tri_512x16_ary_ctl: init sweep, round-robin write arbitration and coherent read port for a 1R1W array
module tri_512x16_ary_ctl #(
    parameter int addressbus_width = 9,
    parameter int port_bitwidth = 16,
    parameter logic [port_bitwidth-1:0] init_value = '0,
    parameter bit init_enable = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        w0_val,
    output logic                        w0_rdy,
    input  logic [addressbus_width-1:0] w0_adr,
    input  logic [port_bitwidth-1:0]    w0_bw,
    input  logic [port_bitwidth-1:0]    w0_di,
    input  logic                        w1_val,
    output logic                        w1_rdy,
    input  logic [addressbus_width-1:0] w1_adr,
    input  logic [port_bitwidth-1:0]    w1_bw,
    input  logic [port_bitwidth-1:0]    w1_di,
    input  logic                        rd_val,
    output logic                        rd_rdy,
    input  logic [addressbus_width-1:0] rd_adr,
    output logic                        rd_data_val,
    output logic [port_bitwidth-1:0]    rd_data,
    output logic                        init_done,
    output logic                        ary_wr_act,
    output logic [addressbus_width-1:0] ary_wr_adr,
    output logic [port_bitwidth-1:0]    ary_bw,
    output logic [port_bitwidth-1:0]    ary_di,
    output logic                        ary_rd_act,
    output logic [addressbus_width-1:0] ary_rd_adr,
    input  logic [port_bitwidth-1:0]    ary_do
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_n;
    logic [addressbus_width-1:0] init_cnt;
    logic rr_ptr, rd_pend, run, hit;
    logic [port_bitwidth-1:0] fwd_bw, fwd_di;

    // state, sweep counter, round-robin pointer and the one-stage read/forward pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= init_enable ? INIT : RUN;
            init_cnt <= '0;
            rr_ptr   <= 1'b0;
            rd_pend  <= 1'b0;
            fwd_bw   <= '0;
            fwd_di   <= '0;
        end else begin
            state   <= state_n;
            rd_pend <= rd_rdy;
            fwd_bw  <= hit ? ary_bw : '0;
            fwd_di  <= ary_di;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (run && w0_val && w1_val) rr_ptr <= ~rr_ptr;
        end
    end

    // next state, arbitration and all port/array drive; everything is forced low while in reset
    always_comb begin
        state_n    = state;
        run        = !reset && state == RUN;
        init_done  = run;
        w0_rdy     = 1'b0;
        w1_rdy     = 1'b0;
        ary_wr_act = 1'b0;
        ary_wr_adr = '0;
        ary_bw     = '0;
        ary_di     = '0;
        if (!reset && state == INIT) begin
            ary_wr_act = 1'b1;
            ary_wr_adr = init_cnt;
            ary_bw     = '1;
            ary_di     = init_value;
            if (init_cnt == '1) state_n = RUN;
        end
        if (run) begin
            w0_rdy     = w0_val && !(w1_val && rr_ptr);
            w1_rdy     = w1_val && !w0_rdy;
            ary_wr_act = w0_rdy || w1_rdy;
            ary_wr_adr = w0_rdy ? w0_adr : w1_rdy ? w1_adr : '0;
            ary_bw     = w0_rdy ? w0_bw : w1_rdy ? w1_bw : '0;
            ary_di     = w0_rdy ? w0_di : w1_rdy ? w1_di : '0;
        end
        rd_rdy      = run && rd_val;
        ary_rd_act  = rd_rdy;
        ary_rd_adr  = rd_rdy ? rd_adr : '0;
        hit         = rd_rdy && ary_wr_act && rd_adr == ary_wr_adr;
        rd_data_val = rd_pend && !reset;
        rd_data     = rd_data_val ? (fwd_bw & fwd_di) | (~fwd_bw & ary_do) : '0;
    end
endmodule

// File: tb/tb_tri_512x16_ary_ctl.sv
// tb_tri_512x16_ary_ctl: random and directed stimulus against a coherent-memory reference model
module tb_tri_512x16_ary_ctl;
    localparam logic [15:0] INIT_V = 16'hA5A5;
    logic clk = 1'b0, reset = 1'b1;
    logic w0_val = 0, w1_val = 0, rd_val = 0;
    logic [8:0] w0_adr = 0, w1_adr = 0, rd_adr = 0;
    logic [15:0] w0_bw = 0, w0_di = 0, w1_bw = 0, w1_di = 0;
    logic w0_rdy, w1_rdy, rd_rdy, rd_data_val, init_done, ary_wr_act, ary_rd_act;
    logic [8:0] ary_wr_adr, ary_rd_adr;
    logic [15:0] rd_data, ary_bw, ary_di, ary_do = 0;
    logic [15:0] arr [512];
    logic [15:0] m_mem [512];
    int n_cmp = 0, n_bad = 0, m_cnt = 0;
    bit m_init = 1, m_rr = 0, m_pend = 0, m_g0 = 0, m_g1 = 0;
    logic [15:0] m_exp = 0;
    logic s_w0, s_w1, s_wa, s_dv, s_done;
    logic [15:0] s_rd;

    tri_512x16_ary_ctl #(.init_value(INIT_V)) dut (
        .clk(clk), .reset(reset),
        .w0_val(w0_val), .w0_rdy(w0_rdy), .w0_adr(w0_adr), .w0_bw(w0_bw), .w0_di(w0_di),
        .w1_val(w1_val), .w1_rdy(w1_rdy), .w1_adr(w1_adr), .w1_bw(w1_bw), .w1_di(w1_di),
        .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_adr(rd_adr), .rd_data_val(rd_data_val), .rd_data(rd_data),
        .init_done(init_done), .ary_wr_act(ary_wr_act), .ary_wr_adr(ary_wr_adr), .ary_bw(ary_bw),
        .ary_di(ary_di), .ary_rd_act(ary_rd_act), .ary_rd_adr(ary_rd_adr), .ary_do(ary_do)
    );

    always #5 clk = ~clk;

    // array macro: registered read of pre-write contents, bit-masked write
    always @(posedge clk) begin
        if (ary_rd_act) ary_do <= arr[ary_rd_adr];
        if (ary_wr_act) arr[ary_wr_adr] <= (arr[ary_wr_adr] & ~ary_bw) | (ary_di & ary_bw);
    end

    task automatic chk(string n, logic [15:0] a, logic [15:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // one clock: compare every output with the model, then advance the model
    task automatic tick();
        logic ew0, ew1, ewa, era, edv, edn;
        logic [8:0] ewad, erad;
        logic [15:0] ebw, edi, erd;
        {ew0, ew1, ewa, era, edv, edn} = '0;
        ewad = '0; erad = '0; ebw = '0; edi = '0; erd = '0;
        @(negedge clk);
        if (!reset) begin
            edv = m_pend;
            erd = m_pend ? m_exp : 16'h0;
            if (m_init) begin
                ewa = 1; ewad = 9'(m_cnt); ebw = 16'hFFFF; edi = INIT_V;
            end else begin
                edn = 1;
                if (w0_val && w1_val) begin ew0 = !m_rr; ew1 = m_rr; end
                else begin ew0 = w0_val; ew1 = w1_val; end
                if (ew0) begin ewa = 1; ewad = w0_adr; ebw = w0_bw; edi = w0_di; end
                else if (ew1) begin ewa = 1; ewad = w1_adr; ebw = w1_bw; edi = w1_di; end
                era = rd_val;
                erad = rd_val ? rd_adr : 9'h0;
            end
        end
        chk("w0_rdy", 16'(w0_rdy), 16'(ew0));
        chk("w1_rdy", 16'(w1_rdy), 16'(ew1));
        chk("rd_rdy", 16'(rd_rdy), 16'(era));
        chk("ary_wr_act", 16'(ary_wr_act), 16'(ewa));
        chk("ary_wr_adr", 16'(ary_wr_adr), 16'(ewad));
        chk("ary_bw", ary_bw, ebw);
        chk("ary_di", ary_di, edi);
        chk("ary_rd_act", 16'(ary_rd_act), 16'(era));
        chk("ary_rd_adr", 16'(ary_rd_adr), 16'(erad));
        chk("rd_data_val", 16'(rd_data_val), 16'(edv));
        chk("rd_data", rd_data, erd);
        chk("init_done", 16'(init_done), 16'(edn));
        s_w0 = w0_rdy; s_w1 = w1_rdy; s_wa = ary_wr_act; s_dv = rd_data_val; s_rd = rd_data; s_done = init_done;
        if (reset) begin
            m_init = 1; m_cnt = 0; m_rr = 0; m_pend = 0;
        end else if (m_init) begin
            m_mem[m_cnt] = INIT_V;
            m_cnt++;
            if (m_cnt == 512) m_init = 0;
            m_pend = 0;
        end else begin
            if (ewa) m_mem[ewad] = (m_mem[ewad] & ~ebw) | (edi & ebw);
            if (w0_val && w1_val) m_rr = !m_rr;
            m_pend = rd_val;
            if (rd_val) m_exp = m_mem[rd_adr];
        end
        m_g0 = ew0; m_g1 = ew1;
        @(posedge clk);
        #1;
    endtask

    task automatic init_stim(bit reqs);
        w0_val = reqs && $urandom_range(0, 1) == 1; w0_adr = 9'($urandom_range(16, 200));
        w1_val = reqs && $urandom_range(0, 1) == 1; w1_adr = 9'($urandom_range(16, 200));
        w0_bw = 16'($urandom); w0_di = 16'($urandom); w1_bw = 16'($urandom); w1_di = 16'($urandom);
        rd_val = 1; rd_adr = 0;
    endtask

    task automatic wait_init(int want);
        bit seen = 0;
        for (int k = 1; k <= 600 && !seen; k++) begin
            init_stim(k < 500);
            tick();
            if (s_done) begin
                seen = 1;
                chk("init_done_cycle", 16'(k), 16'(want));
            end
        end
        if (!seen) chk("init_done_timeout", 16'(0), 16'(1));
        w0_val = 0; w1_val = 0; rd_val = 0;
    endtask

    task automatic rd_lit(string n, logic [8:0] a, logic [15:0] e);
        rd_val = 1; rd_adr = a;
        tick();
        rd_val = 0;
        tick();
        chk(n, s_rd, e);
    endtask

    initial begin
        #1;
        repeat (3) begin
            init_stim(1);
            tick();
        end
        reset = 0;
        for (int i = 0; i < 300; i++) begin
            init_stim(1);
            tick();
        end
        reset = 1;
        tick();
        tick();
        reset = 0;
        wait_init(513);
        tick();
        chk("first_run_read_val", 16'(s_dv), 16'(1));
        chk("first_run_read_data", s_rd, 16'hA5A5);
        rd_lit("read_0", 9'd0, 16'hA5A5);
        rd_lit("read_255", 9'd255, 16'hA5A5);
        rd_lit("read_511", 9'd511, 16'hA5A5);
        w0_val = 1; w0_adr = 20; w0_bw = 16'hFFFF; w0_di = 16'h1111;
        w1_val = 1; w1_adr = 21; w1_bw = 16'hFFFF; w1_di = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arb_contested_w0", 16'(s_w0), 16'(i % 2 == 0));
            chk("arb_contested_w1", 16'(s_w1), 16'(i % 2 == 1));
        end
        w0_val = 0;
        tick();
        chk("arb_w1_alone", 16'(s_w1), 16'(1));
        w0_val = 1;
        tick();
        chk("arb_after_alone_w0", 16'(s_w0), 16'(1));
        w1_val = 0;
        w0_adr = 5; w0_bw = 16'hFFFF; w0_di = 16'h1234;
        tick();
        w0_bw = 16'h00FF; w0_di = 16'hABCD; rd_val = 1; rd_adr = 5;
        tick();
        w0_val = 0;
        tick();
        chk("fwd_same_cycle", s_rd, 16'h12CD);
        rd_val = 0;
        tick();
        chk("fwd_from_array", s_rd, 16'h12CD);
        w0_val = 1; w0_adr = 7; w0_bw = 16'hFFFF; w0_di = 16'h7777;
        tick();
        w0_bw = 16'h0000; w0_di = 16'hFFFF;
        tick();
        chk("bw0_rdy", 16'(s_w0), 16'(1));
        chk("bw0_wr_act", 16'(s_wa), 16'(1));
        w0_val = 0;
        rd_lit("bw0_unchanged", 9'd7, 16'h7777);
        for (int i = 0; i < 2000; i++) begin
            if (!(w0_val && !m_g0)) begin
                w0_val = $urandom_range(0, 1) == 1; w0_adr = 9'($urandom_range(0, 15));
                w0_bw = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom); w0_di = 16'($urandom);
            end
            if (!(w1_val && !m_g1)) begin
                w1_val = $urandom_range(0, 1) == 1; w1_adr = 9'($urandom_range(0, 15));
                w1_bw = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom); w1_di = 16'($urandom);
            end
            rd_val = $urandom_range(0, 2) != 0; rd_adr = 9'($urandom_range(0, 15));
            tick();
        end
        w0_val = 0; w1_val = 0;
        rd_val = 1; rd_adr = 3;
        tick();
        rd_val = 0; reset = 1;
        tick();
        chk("reset_kills_read", 16'(s_dv), 16'(0));
        reset = 0;
        tick();
        chk("no_val_after_reset", 16'(s_dv), 16'(0));
        tick();
        chk("no_val_after_reset2", 16'(s_dv), 16'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
